// File: rtl/b_dly_line_prm_pkg.sv
// b_dly_line_prm_pkg: shared modes, select-FSM states and elaboration helpers for the delay line.
package b_dly_line_prm_pkg;

    localparam int MODE_IMM  = 0;
    localparam int MODE_RAMP = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/b_dly_line_prm_ram.sv
// b_dly_line_prm_ram: shared history storage, one write port and one asynchronous read port per channel.
module b_dly_line_prm_ram #(
    parameter int DW    = 1,
    parameter int NCH   = 2,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [NCH*DW-1:0] i_wdata,
    input  logic [NCH*AW-1:0] i_raddr,
    output logic [NCH*DW-1:0] o_rdata
);

    logic [NCH*DW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) mem[i_waddr] <= i_wdata;

    // each channel only ever needs its own lane of the shared word
    for (genvar c = 0; c < NCH; c++) begin : g_rd
        assign o_rdata[c*DW +: DW] = mem[i_raddr[c*AW +: AW]][c*DW +: DW];
    end

endmodule

// File: rtl/b_dly_line_prm.sv
// b_dly_line_prm: multi-channel programmable delay line over one circular history buffer,
// with immediate or one-step-per-cycle ramped select updates.
module b_dly_line_prm
    import b_dly_line_prm_pkg::*;
#(
    parameter int DW    = 1,
    parameter int NCH   = 2,
    parameter int DEPTH = 256,
    parameter int SELW  = 8,
    parameter int MODE  = 0
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [NCH*DW-1:0]   i_in,
    input  logic                i_sel_vld,
    input  logic [NCH*SELW-1:0] i_sel,
    output logic                o_sel_rdy,
    output logic [NCH*SELW-1:0] o_cur_sel,
    output logic [NCH*DW-1:0]   o_out,
    output logic [NCH-1:0]      o_vld
);

    if (DEPTH != 2**SELW || SELW != clog2_f(DEPTH) || (MODE != MODE_IMM && MODE != MODE_RAMP)) begin : g_bad_cfg
        $error("b_dly_line_prm: DEPTH must equal 2**SELW and MODE must be 0 or 1");
    end

    localparam logic [SELW:0] FULL = (SELW+1)'(DEPTH);

    logic [SELW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [SELW:0]       fill_q, fill_d;
    logic [NCH*SELW-1:0] cur_sel_q, tgt_sel_q, step_sel, raddr;
    logic [NCH*DW-1:0]   out_q, out_d, tap, rdata;
    logic [NCH-1:0]      vld_q, vld_d, tap_vld;
    state_e              state_q;
    logic                wr_en, xfer;

    assign wr_en     = i_en && !i_clr;
    assign xfer      = i_sel_vld && o_sel_rdy;
    assign o_sel_rdy = (state_q == ST_IDLE);
    assign o_cur_sel = cur_sel_q;
    assign o_out     = out_q;
    assign o_vld     = vld_q;

    b_dly_line_prm_ram #(
        .DW    (DW),
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .AW    (SELW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_in),
        .i_raddr (raddr),
        .o_rdata (rdata)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SELW-1:0] cs, ts;
        assign cs = cur_sel_q[c*SELW +: SELW];
        assign ts = tgt_sel_q[c*SELW +: SELW];
        // ramps move linearly toward the target, never across the wrap
        assign step_sel[c*SELW +: SELW] = (cs < ts) ? cs + 1'b1 : (cs > ts) ? cs - 1'b1 : cs;
        assign raddr[c*SELW +: SELW]    = wr_ptr_q - cs;
        assign tap[c*DW +: DW]          = (cs == '0) ? i_in[c*DW +: DW] : rdata[c*DW +: DW];
        assign tap_vld[c]               = (fill_q >= {1'b0, cs});
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d   = i_clr ? '0 : (!i_en || fill_q == FULL) ? fill_q : fill_q + 1'b1;
        out_d    = i_clr ? '0 : i_en ? tap : out_q;
        vld_d    = i_clr ? '0 : i_en ? tap_vld : vld_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn)
        if (!i_rstn) begin
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            out_q     <= '0;
            vld_q     <= '0;
            cur_sel_q <= '0;
            tgt_sel_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            if (i_clr) begin
                cur_sel_q <= xfer ? i_sel : tgt_sel_q;
                tgt_sel_q <= xfer ? i_sel : tgt_sel_q;
                state_q   <= ST_IDLE;
            end else if (MODE == MODE_IMM) begin
                if (xfer) begin
                    cur_sel_q <= i_sel;
                    tgt_sel_q <= i_sel;
                end
            end else if (state_q == ST_IDLE) begin
                if (xfer) begin
                    tgt_sel_q <= i_sel;
                    state_q   <= (i_sel != cur_sel_q) ? ST_RAMP : ST_IDLE;
                end
            end else if (i_en) begin
                cur_sel_q <= step_sel;
                state_q   <= (step_sel == tgt_sel_q) ? ST_IDLE : ST_RAMP;
            end
        end

endmodule
